// File: rtl/wb_write_queue_if.sv
// wb_write_queue_if: bundles the push, drain, bypass and status signals
// of the writeback queue.
//   master : producer / register-file / decode side (drives in_*, wb_hold, SrcReg*)
//   slave  : queue side (drives in_ready, WriteReg, DstReg, DstData, byp_*, occupancy, empty)
// DEPTH must match the DEPTH of the attached wb_write_queue.
interface wb_write_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // push channel
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_reg;
    logic [15:0]   in_data;

    // register file write port
    logic          wb_hold;
    logic          WriteReg;
    logic [3:0]    DstReg;
    logic [15:0]   DstData;

    // decode bypass lookups
    logic [3:0]    SrcReg1;
    logic [3:0]    SrcReg2;
    logic          byp_hit1;
    logic [15:0]   byp_data1;
    logic          byp_hit2;
    logic [15:0]   byp_data2;

    // status
    logic [CW-1:0] occupancy;
    logic          empty;

    modport master (
        output in_valid, in_reg, in_data, wb_hold, SrcReg1, SrcReg2,
        input  in_ready, WriteReg, DstReg, DstData,
        input  byp_hit1, byp_data1, byp_hit2, byp_data2, occupancy, empty
    );

    modport slave (
        input  in_valid, in_reg, in_data, wb_hold, SrcReg1, SrcReg2,
        output in_ready, WriteReg, DstReg, DstData,
        output byp_hit1, byp_data1, byp_hit2, byp_data2, occupancy, empty
    );
endinterface

// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order buffer of completed results in front of the
// 16x16 register file write port. Drains one entry per cycle unless
// wb_hold is set, and offers two bypass lookups over queued entries.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : wb_write_queue_if.slave (push, drain, bypass, status)
// Parameters:
//   DEPTH            : entries, power of 2, >= 2
//   ZERO_REG_DISCARD : 1 = pushes to R0 complete the handshake but are dropped
// Build option:
//   WBQ_BYPASS_EN    : when defined, bypass comparators are built; otherwise
//                      byp_hit*/byp_data* are tied to 0.
module wb_write_queue #(
    parameter int unsigned DEPTH            = 4,
    parameter int unsigned ZERO_REG_DISCARD = 1
) (
    input logic             clk,
    input logic             rst,
    wb_write_queue_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [3:0]  rd;
        logic [15:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          discard_c;
    logic          push_c;
    logic          store_c;
    logic          pop_c;
    entry_t        head_c;

    // Status and drain outputs; in_ready depends on registered count only.
    assign bus.in_ready  = (count_q < CW'(DEPTH));
    assign bus.empty     = (count_q == '0);
    assign bus.occupancy = count_q;

    assign head_c       = mem_q[rd_ptr_q];
    assign bus.WriteReg = pop_c;
    assign bus.DstReg   = pop_c ? head_c.rd   : 4'd0;
    assign bus.DstData  = pop_c ? head_c.data : 16'd0;

    // Handshake decode and next-state pointers/count.
    always_comb begin
        discard_c = (ZERO_REG_DISCARD != 0) && (bus.in_reg == 4'd0);
        push_c    = bus.in_valid && bus.in_ready;
        store_c   = push_c && !discard_c;
        pop_c     = (count_q != '0) && !bus.wb_hold;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (store_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (store_c && !pop_c) begin
            count_d = count_q + CW'(1);
        end else if (pop_c && !store_c) begin
            count_d = count_q - CW'(1);
        end
    end

    // State and storage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (store_c) begin
                mem_q[wr_ptr_q] <= '{rd: bus.in_reg, data: bus.in_data};
            end
        end
    end

`ifdef WBQ_BYPASS_EN
    logic [AW-1:0] idx_c;
    logic          blk1_c;
    logic          blk2_c;
    logic          hit1_c, hit2_c;
    logic [15:0]   data1_c, data2_c;

    // Walk live entries oldest to youngest so the youngest match wins.
    always_comb begin
        blk1_c  = (ZERO_REG_DISCARD != 0) && (bus.SrcReg1 == 4'd0);
        blk2_c  = (ZERO_REG_DISCARD != 0) && (bus.SrcReg2 == 4'd0);
        hit1_c  = 1'b0;
        hit2_c  = 1'b0;
        data1_c = 16'd0;
        data2_c = 16'd0;
        idx_c   = rd_ptr_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx_c = rd_ptr_q + AW'(i);
            if (CW'(i) < count_q) begin
                if (!blk1_c && (mem_q[idx_c].rd == bus.SrcReg1)) begin
                    hit1_c  = 1'b1;
                    data1_c = mem_q[idx_c].data;
                end
                if (!blk2_c && (mem_q[idx_c].rd == bus.SrcReg2)) begin
                    hit2_c  = 1'b1;
                    data2_c = mem_q[idx_c].data;
                end
            end
        end
    end

    assign bus.byp_hit1  = hit1_c;
    assign bus.byp_data1 = data1_c;
    assign bus.byp_hit2  = hit2_c;
    assign bus.byp_data2 = data2_c;
`else
    // Lookup addresses are intentionally ignored in this build.
    logic unused_src;
    assign unused_src    = ^{bus.SrcReg1, bus.SrcReg2};

    assign bus.byp_hit1  = 1'b0;
    assign bus.byp_data1 = 16'h0000;
    assign bus.byp_hit2  = 1'b0;
    assign bus.byp_data2 = 16'h0000;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed scenarios followed by random traffic, all
// compared every cycle against a queue-based reference model.
module tb_wb_write_queue;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [3:0]  r;
        logic [15:0] d;
    } ent_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    ent_t mq[$];

    wb_write_queue_if #(.DEPTH(DEPTH)) bus ();

    wb_write_queue #(.DEPTH(DEPTH), .ZERO_REG_DISCARD(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Youngest stored entry whose register matches src.
    task automatic model_lookup(input logic [3:0] src, output logic hit, output logic [15:0] data);
        hit  = 1'b0;
        data = 16'd0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].r == src) begin
                hit  = 1'b1;
                data = mq[i].d;
                break;
            end
        end
`ifndef WBQ_BYPASS_EN
        hit  = 1'b0;
        data = 16'd0;
`endif
    endtask

    // Called just after an edge with inputs already driven: checks outputs
    // mid-cycle, advances one clock, then updates the model.
    task automatic tick();
        logic        exp_we;
        logic        acc;
        logic        h1, h2;
        logic [15:0] d1, d2;
        ent_t        e;
        #3;
        exp_we = (mq.size() != 0) && !bus.wb_hold;
        acc    = bus.in_valid && (mq.size() < DEPTH);
        chk("in_ready",  32'(bus.in_ready),  32'(mq.size() < DEPTH));
        chk("occupancy", 32'(bus.occupancy), 32'(mq.size()));
        chk("empty",     32'(bus.empty),     32'(mq.size() == 0));
        chk("WriteReg",  32'(bus.WriteReg),  32'(exp_we));
        if (exp_we) begin
            chk("DstReg",  32'(bus.DstReg),  32'(mq[0].r));
            chk("DstData", 32'(bus.DstData), 32'(mq[0].d));
        end
        model_lookup(bus.SrcReg1, h1, d1);
        model_lookup(bus.SrcReg2, h2, d2);
        chk("byp_hit1",  32'(bus.byp_hit1),  32'(h1));
        chk("byp_data1", 32'(bus.byp_data1), 32'(d1));
        chk("byp_hit2",  32'(bus.byp_hit2),  32'(h2));
        chk("byp_data2", 32'(bus.byp_data2), 32'(d2));
        e.r = bus.in_reg;
        e.d = bus.in_data;
        @(posedge clk);
        if (exp_we) void'(mq.pop_front());
        if (acc && (e.r != 4'd0)) mq.push_back(e);
        #1;
    endtask

    task automatic push(input logic [3:0] r, input logic [15:0] d);
        bus.in_valid = 1'b1;
        bus.in_reg   = r;
        bus.in_data  = d;
        tick();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        bus.in_valid  = 1'b0;
        bus.in_reg    = 4'd0;
        bus.in_data   = 16'd0;
        bus.wb_hold   = 1'b0;
        bus.SrcReg1   = 4'd0;
        bus.SrcReg2   = 4'd0;
        rst           = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // reset state while asserted
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_WriteReg", 32'(bus.WriteReg), 32'd0);
        chk("rst_DstReg",   32'(bus.DstReg),   32'd0);
        chk("rst_DstData",  32'(bus.DstData),  32'd0);
        chk("rst_occ",      32'(bus.occupancy), 32'd0);
        chk("rst_empty",    32'(bus.empty),    32'd1);
        chk("rst_hit1",     32'(bus.byp_hit1), 32'd0);
        chk("rst_data2",    32'(bus.byp_data2), 32'd0);
        rst = 1'b1;
        tick();

        // reset mid-queue
        bus.wb_hold = 1'b1;
        push(4'd3, 16'h1111);
        push(4'd4, 16'h2222);
        bus.in_valid = 1'b0;
        chk("pre_rst_occ", 32'(bus.occupancy), 32'd2);
        #1 rst = 1'b0;
        bus.wb_hold = 1'b0;
        #1;
        chk("mid_rst_occ",      32'(bus.occupancy), 32'd0);
        chk("mid_rst_empty",    32'(bus.empty),     32'd1);
        chk("mid_rst_WriteReg", 32'(bus.WriteReg),  32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready),  32'd1);
        mq.delete();
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) tick();

        // basic drain
        push(4'd5, 16'hABCD);
        bus.in_valid = 1'b0;
        #3;
        chk("drain_we",   32'(bus.WriteReg), 32'd1);
        chk("drain_reg",  32'(bus.DstReg),   32'd5);
        chk("drain_data", 32'(bus.DstData),  32'hABCD);
        #(-0);
        @(posedge clk);
        #1;
        void'(mq.pop_front());
        chk("drain_empty", 32'(bus.empty), 32'd1);
        tick();

        // fill and stall, then drain across the pointer wrap
        bus.wb_hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(4'(i), 16'(i));
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        push(4'd6, 16'h0005);
        push(4'd6, 16'h0005);
        bus.in_valid = 1'b0;
        bus.wb_hold  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #3;
            chk("fill_drain_reg", 32'(bus.DstReg), 32'(i));
            #(-0);
            tick_rest();
        end
        tick();

        // simultaneous push and pop at occupancy 2
        bus.wb_hold = 1'b1;
        push(4'd8, 16'h0808);
        push(4'd9, 16'h0909);
        bus.wb_hold = 1'b0;
        push(4'd10, 16'h0A0A);
        push(4'd11, 16'h0B0B);
        push(4'd12, 16'h0C0C);
        chk("sim_occ", 32'(bus.occupancy), 32'd2);
        bus.in_valid = 1'b0;
        repeat (3) tick();

        // bypass youngest wins
        bus.wb_hold = 1'b1;
        push(4'd7, 16'h00AA);
        push(4'd2, 16'h0BBB);
        push(4'd7, 16'h00CC);
        bus.in_valid = 1'b0;
        bus.SrcReg1  = 4'd7;
        bus.SrcReg2  = 4'd9;
        #1;
`ifdef WBQ_BYPASS_EN
        chk("byp_yw_hit1",  32'(bus.byp_hit1),  32'd1);
        chk("byp_yw_data1", 32'(bus.byp_data1), 32'h00CC);
`else
        chk("byp_off_hit1",  32'(bus.byp_hit1),  32'd0);
        chk("byp_off_data1", 32'(bus.byp_data1), 32'd0);
`endif
        chk("byp_yw_hit2",  32'(bus.byp_hit2),  32'd0);
        chk("byp_yw_data2", 32'(bus.byp_data2), 32'd0);
        @(posedge clk);
        #1;
        bus.wb_hold = 1'b0;
        repeat (4) tick();

        // R0 discard
        bus.SrcReg1 = 4'd0;
        push(4'd0, 16'hFFFF);
        bus.in_valid = 1'b0;
        chk("r0_occ", 32'(bus.occupancy), 32'd0);
        repeat (2) tick();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_reg   = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            bus.in_data  = 16'($urandom);
            bus.wb_hold  = ($urandom_range(0, 9) < 4);
            bus.SrcReg1  = 4'($urandom);
            bus.SrcReg2  = 4'($urandom_range(0, 3));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Remainder of a tick when the caller already waited the #3 mid-cycle point.
    task automatic tick_rest();
        #(-0);
        begin
            logic exp_we;
            exp_we = (mq.size() != 0) && !bus.wb_hold;
            chk("fr_WriteReg", 32'(bus.WriteReg), 32'(exp_we));
            if (exp_we) chk("fr_DstData", 32'(bus.DstData), 32'(mq[0].d));
            @(posedge clk);
            if (exp_we) void'(mq.pop_front());
            #1;
        end
    endtask

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Writeback-side buffer sitting directly upstream of the 16x16 register file write port.
- Accepts completed results (destination register + 16-bit data) from the execute/memory stages via a valid/ready handshake.
- Holds results in a small in-order FIFO and drains one entry per cycle into the register file's DstReg/DstData/WriteReg inputs.
- Provides two bypass lookups so decode can see values that are still queued and not yet written.

Parameters:
- DEPTH, 4, number of queued entries; power of 2, minimum 2.
- ZERO_REG_DISCARD, 1, when 1 a push targeting register 0 is accepted but not stored.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  producer has a result
- in_ready  out  1  queue can accept this cycle
- in_reg  in  4  destination register of incoming result
- in_data  in  16  incoming result value
- wb_hold  in  1  write port unavailable this cycle; suppresses drain
- WriteReg  out  1  write enable to register file
- DstReg  out  4  register file write address
- DstData  out  16  register file write data
- SrcReg1  in  4  bypass lookup address 1, same as register file read port 1
- SrcReg2  in  4  bypass lookup address 2
- byp_hit1  out  1  SrcReg1 matches a queued entry
- byp_data1  out  16  youngest matching queued data for SrcReg1
- byp_hit2  out  1  as byp_hit1, for SrcReg2
- byp_data2  out  16  as byp_data1, for SrcReg2
- occupancy  out  clog2(DEPTH)+1  number of stored entries
- empty  out  1  occupancy == 0

Behaviour:
- Storage: DEPTH entries of {reg[3:0], data[15:0]}. Read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Count is held in a separate register.
- Reset (rst low, asynchronous): pointers, count and all entry fields go to 0, discarding in-flight entries mid-operation. While reset is asserted and after release:
  - in_ready=1, WriteReg=0, DstReg=0, DstData=0
  - byp_hit*=0, byp_data*=0
  - occupancy=0, empty=1
- in_ready = (count < DEPTH). It depends only on registered state: no combinational path from wb_hold or in_valid. A push is not accepted on a full cycle even if a pop occurs in the same cycle.
- Push: occurs when in_valid && in_ready. The entry is stored at the write pointer on the rising edge and the write pointer advances.
  - If ZERO_REG_DISCARD=1 and in_reg==0, the handshake completes but nothing is stored and count is unchanged.
- Drain (combinational from head):
  - WriteReg = !empty && !wb_hold
  - DstReg, DstData = head entry fields, valid only while WriteReg=1
  - The pop happens on the same edge the register file captures the write.
- Latency: an entry pushed at edge N reaches the head no earlier than after edge N; its earliest register file write is edge N+1.
- Ordering is strictly FIFO. Two queued writes to the same register are both performed, oldest first.
- Simultaneous push and pop: both pointers advance and count is unchanged.
- count increments on push-only, decrements on pop-only, and never underflows or overflows.
- wb_hold=1 freezes the head. Pushes continue until full.
- Bypass (per port k):
  - byp_hit_k = 1 if any stored entry has reg == SrcReg_k.
  - byp_data_k = data of the youngest such entry, searched from write pointer minus 1 backwards. It is 0 when there is no hit.
  - The entry being popped this cycle still participates. The entry being pushed this cycle does not; the producer is responsible for forwarding its own in-flight value.
  - SrcReg_k==0 never hits when ZERO_REG_DISCARD=1.
- Bypass outputs are purely combinational from stored state and SrcReg inputs.

Optional Feature:
- Macro WBQ_BYPASS_EN.
- Defined: the bypass lookup logic is built as described above.
- Undefined: byp_hit1/2 are tied to 0 and byp_data1/2 to 16'h0000, and no comparators are instantiated. Decode must instead stall until empty before reading a register with a pending write.
- Queue and drain behaviour is identical in both builds.

Test Plan:
- Reset mid-queue: push (R3,16'h1111) and (R4,16'h2222), hold wb_hold=1, pulse rst low between clock edges.
  -> Immediately occupancy=0, empty=1, WriteReg=0, in_ready=1. After release, neither value is ever written.
- Basic drain: push (R5,16'hABCD) at edge 1, wb_hold=0.
  -> Cycle after edge 1: WriteReg=1, DstReg=5, DstData=16'hABCD. After edge 2: empty=1.
- Fill and stall: wb_hold=1, push R1..R4 with data 16'h0001..16'h0004, then hold in_valid=1 for 2 more cycles.
  -> in_ready=0 at occupancy=4, and the 5th push is not accepted. Release hold: writes occur on 4 consecutive edges, R1 first, and pointers wrap correctly.
- Simultaneous push/pop at occupancy=2 with wb_hold=0.
  -> occupancy stays 2 across 3 cycles, and writes emerge in push order.
- Bypass youngest-wins (WBQ_BYPASS_EN defined): wb_hold=1, push (R7,16'h00AA), (R2,16'h0BBB), (R7,16'h00CC); set SrcReg1=7, SrcReg2=9.
  -> byp_hit1=1, byp_data1=16'h00CC, byp_hit2=0, byp_data2=0. Without the macro, all bypass outputs are 0.
- R0 discard: push (R0,16'hFFFF) with in_valid=1 on an empty queue.
  -> in_ready=1, occupancy stays 0, WriteReg never asserts, and SrcReg1=0 gives byp_hit1=0.
